apuracao_votos: RTL

//   Collects one day-phase vote per living player and tallies them. Picks the most-voted player.

---
 rtl/apuracao_votos.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/apuracao_votos.sv
// Day-phase vote collector: accepts one vote per living player, then scans the
// tallies one candidate per cycle and reports the most-voted player or a tie.
module apuracao_votos #(
  parameter int N_JOG = 5,
  parameter int W     = 3,
  parameter int CW    = 3
) (
  input  logic             clock,
  input  logic             rst_global,
  input  logic             iniciar,
  input  logic             encerrar,
  input  logic             voto_valido,
  input  logic [W-1:0]     eleitor,
  input  logic [W-1:0]     alvo,
  input  logic [N_JOG-1:0] mortes,
  output logic             voto_aceito,
  output logic             voto_rejeitado,
  output logic [W-1:0]     votos_recebidos,
  output logic             ocupado,
  output logic             pronto,
  output logic [W-1:0]     eliminado,
  output logic             empate,
  output logic [1:0]       db_estado
);

  localparam logic [1:0]   OCIOSO    = 2'd0;
  localparam logic [1:0]   COLETA    = 2'd1;
  localparam logic [1:0]   APURA     = 2'd2;
  localparam logic [1:0]   RESULTADO = 2'd3;
  localparam logic [W-1:0] NENHUM    = W'(5);
  localparam logic [W-1:0] ULTIMO    = W'(N_JOG - 1);

  logic [1:0]       r_estado;
  logic             r_ocupado;
  logic [CW-1:0]    r_tally [N_JOG];
  logic [N_JOG-1:0] r_ja_votou;
  logic [N_JOG-1:0] r_vivos;
  logic [W-1:0]     r_votos;
  logic             r_aceito;
  logic             r_rejeitado;
  logic             r_pronto;
  logic [W-1:0]     r_eliminado;
  logic             r_empate;
  logic [W-1:0]     r_idx;
  logic [CW-1:0]    r_max;
  logic [W-1:0]     r_arg;
  logic             r_tie;

  logic [1:0]       w_estado_n;
  logic             w_ocupado_n;
  logic [N_JOG-1:0] w_eleitor_oh;
  logic [N_JOG-1:0] w_alvo_oh;
  logic [CW-1:0]    w_tally_cur;
  logic             w_eleitor_ok;
  logic             w_alvo_ok;
  logic             w_aceita;
  logic [N_JOG-1:0] w_ja_votou_n;
  logic [CW-1:0]    w_max_n;
  logic [W-1:0]     w_arg_n;
  logic             w_tie_n;
  logic [W-1:0]     w_elim_n;
  logic             w_empate_n;

  // Decode voter/target into one-hot masks and pick the tally under scan.
  always_comb begin
    w_eleitor_oh = '0;
    w_alvo_oh    = '0;
    w_tally_cur  = '0;
    for (int i = 0; i < N_JOG; i++) begin
      w_eleitor_oh[i] = (eleitor == W'(i));
      w_alvo_oh[i]    = (alvo == W'(i));
      w_tally_cur     = (r_idx == W'(i)) ? r_tally[i] : w_tally_cur;
    end
  end

  assign w_eleitor_ok = |(w_eleitor_oh & r_vivos & ~r_ja_votou);
  assign w_alvo_ok    = (|(w_alvo_oh & r_vivos)) || (alvo == NENHUM);
  assign w_aceita     = voto_valido && (r_estado == COLETA) && w_eleitor_ok && w_alvo_ok;
  assign w_ja_votou_n = r_ja_votou | (w_aceita ? w_eleitor_oh : {N_JOG{1'b0}});

  // One scan step of the max/arg/tie search plus the verdict it implies.
  always_comb begin
    w_max_n    = r_max;
    w_arg_n    = r_arg;
    w_tie_n    = r_tie;
    w_elim_n   = NENHUM;
    w_empate_n = 1'b0;
    if (w_tally_cur > r_max) begin
      w_max_n = w_tally_cur;
      w_arg_n = r_idx;
      w_tie_n = 1'b0;
    end else if ((w_tally_cur == r_max) && (r_max != {CW{1'b0}})) begin
      w_tie_n = 1'b1;
    end else begin
      w_tie_n = r_tie;
    end
    if (w_max_n == {CW{1'b0}}) begin
      w_elim_n   = NENHUM;
      w_empate_n = 1'b0;
    end else if (w_tie_n) begin
      w_elim_n   = NENHUM;
      w_empate_n = 1'b1;
    end else begin
      w_elim_n   = w_arg_n;
      w_empate_n = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge rst_global) begin
    if (rst_global) begin
      r_estado  <= OCIOSO;
      r_ocupado <= 1'b0;
    end else begin
      r_estado  <= w_estado_n;
      r_ocupado <= w_ocupado_n;
    end
  end

  // Next-state logic; iniciar restarts collection from any state.
  always_comb begin
    w_estado_n = r_estado;
    if (iniciar) begin
      w_estado_n = COLETA;
    end else begin
      case (r_estado)
        OCIOSO:    w_estado_n = OCIOSO;
        COLETA:    w_estado_n = (encerrar || (w_ja_votou_n == r_vivos)) ? APURA : COLETA;
        APURA:     w_estado_n = (r_idx == ULTIMO) ? RESULTADO : APURA;
        RESULTADO: w_estado_n = OCIOSO;
        default:   w_estado_n = OCIOSO;
      endcase
    end
  end

  // Output decode, registered alongside the state.
  always_comb begin
    case (w_estado_n)
      COLETA:  w_ocupado_n = 1'b1;
      APURA:   w_ocupado_n = 1'b1;
      default: w_ocupado_n = 1'b0;
    endcase
  end

  // Datapath: tallies, vote bookkeeping, scan registers and result.
  always_ff @(posedge clock or posedge rst_global) begin
    if (rst_global) begin
      for (int i = 0; i < N_JOG; i++) r_tally[i] <= '0;
      r_ja_votou  <= '0;
      r_vivos     <= '0;
      r_votos     <= '0;
      r_aceito    <= 1'b0;
      r_rejeitado <= 1'b0;
      r_pronto    <= 1'b0;
      r_eliminado <= NENHUM;
      r_empate    <= 1'b0;
      r_idx       <= '0;
      r_max       <= '0;
      r_arg       <= '0;
      r_tie       <= 1'b0;
    end else begin
      r_aceito    <= 1'b0;
      r_rejeitado <= 1'b0;
      r_pronto    <= 1'b0;
      if (iniciar) begin
        for (int i = 0; i < N_JOG; i++) r_tally[i] <= '0;
        r_ja_votou  <= '0;
        r_vivos     <= ~mortes;
        r_votos     <= '0;
        r_eliminado <= NENHUM;
        r_empate    <= 1'b0;
        r_idx       <= '0;
        r_max       <= '0;
        r_arg       <= '0;
        r_tie       <= 1'b0;
      end else begin
        r_aceito    <= voto_valido && w_aceita;
        r_rejeitado <= voto_valido && !w_aceita;
        if (w_aceita) begin
          r_votos <= r_votos + W'(1);
          for (int i = 0; i < N_JOG; i++) begin
            if (w_alvo_oh[i]) r_tally[i] <= r_tally[i] + CW'(1);
            else              r_tally[i] <= r_tally[i];
          end
        end else begin
          r_votos <= r_votos;
        end
        r_ja_votou <= w_ja_votou_n;
        if (r_estado == APURA) begin
          r_idx <= r_idx + W'(1);
          r_max <= w_max_n;
          r_arg <= w_arg_n;
          r_tie <= w_tie_n;
          if (r_idx == ULTIMO) begin
            r_eliminado <= w_elim_n;
            r_empate    <= w_empate_n;
            r_pronto    <= 1'b1;
          end else begin
            r_pronto    <= 1'b0;
          end
        end else begin
          r_idx <= '0;
          r_max <= '0;
          r_arg <= '0;
          r_tie <= 1'b0;
        end
      end
    end
  end

  assign voto_aceito     = r_aceito;
  assign voto_rejeitado  = r_rejeitado;
  assign votos_recebidos = r_votos;
  assign ocupado         = r_ocupado;
  assign pronto          = r_pronto;
  assign eliminado       = r_eliminado;
  assign empate          = r_empate;
  assign db_estado       = r_estado;

endmodule
